// File: rtl/ptw_req_dedup_queue.sv
// In-order request scoreboard behind the PTW request arbiter: buffers requests, drops
// null requests and duplicate addresses, issues to memory and retires on in-order responses.
module ptw_req_dedup_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 27,
   localparam int IDX_W = $clog2(DEPTH),
   localparam int PTR_W = IDX_W + 1
) (
   input  logic              clock,
   input  logic              reset,
   output logic              io_enq_ready,
   input  logic              io_enq_valid,
   input  logic              io_enq_bits_valid,
   input  logic [ADDR_W-1:0] io_enq_bits_bits_addr,
   input  logic              io_deq_ready,
   output logic              io_deq_valid,
   output logic [ADDR_W-1:0] io_deq_bits_addr,
   input  logic              io_resp_valid,
   output logic              io_resp_err,
   output logic [PTR_W-1:0]  io_count,
   output logic [7:0]        io_drop_count
);

   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [PTR_W-1:0]  iss_q, iss_d;
   logic [PTR_W-1:0]  head_q, head_d;
   logic [7:0]        drop_count_q, drop_count_d;
   logic              resp_err_q, resp_err_d;
   logic [ADDR_W-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0]  occupancy;
   logic [PTR_W-1:0]  pending;
   logic [PTR_W-1:0]  inflight;
   logic [DEPTH-1:0]  match_vec;
   logic              addr_hit;
   logic              enq_fire;
   logic              enq_store;
   logic              enq_drop;
   logic              deq_fire;

   assign occupancy = tail_q - head_q;
   assign pending   = tail_q - iss_q;
   assign inflight  = iss_q - head_q;

   // A slot is allocated when its distance from head (mod DEPTH) is below the occupancy;
   // this covers both pending and in-flight entries, including one retiring this cycle.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
         logic [IDX_W-1:0] slot_off;
         assign slot_off      = IDX_W'(gi) - head_q[IDX_W-1:0];
         assign match_vec[gi] = ({1'b0, slot_off} < occupancy) &&
                                (mem_q[gi] == io_enq_bits_bits_addr);
      end
   endgenerate

   assign addr_hit  = |match_vec;
   assign enq_fire  = io_enq_valid & io_enq_ready;
   assign enq_store = enq_fire & io_enq_bits_valid & ~addr_hit;
   assign enq_drop  = enq_fire & ~enq_store;
   assign deq_fire  = io_deq_valid & io_deq_ready;

   always_comb begin
      tail_d       = tail_q;
      iss_d        = iss_q;
      head_d       = head_q;
      drop_count_d = drop_count_q;
      resp_err_d   = 1'b0;
      if (enq_store) begin
         tail_d = tail_q + PTR_W'(1);
      end
      if (enq_drop && (drop_count_q != 8'hFF)) begin
         drop_count_d = drop_count_q + 8'd1;
      end
      if (deq_fire) begin
         iss_d = iss_q + PTR_W'(1);
      end
      if (io_resp_valid) begin
         if (inflight != '0) begin
            head_d = head_q + PTR_W'(1);
         end else begin
            resp_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tail_q       <= '0;
         iss_q        <= '0;
         head_q       <= '0;
         drop_count_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         tail_q       <= tail_d;
         iss_q        <= iss_d;
         head_q       <= head_d;
         drop_count_q <= drop_count_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Entry storage carries no reset; only slots inside [head, tail) are ever trusted.
   always_ff @(posedge clock) begin
      if (!reset && enq_store) begin
         mem_q[tail_q[IDX_W-1:0]] <= io_enq_bits_bits_addr;
      end
   end

   assign io_enq_ready     = (occupancy != PTR_W'(DEPTH));
   assign io_deq_valid     = (pending != '0);
   assign io_deq_bits_addr = mem_q[iss_q[IDX_W-1:0]];
   assign io_resp_err      = resp_err_q;
   assign io_count         = occupancy;
   assign io_drop_count    = drop_count_q;

endmodule

// File: tb/tb_ptw_req_dedup_queue.sv
// Directed bench for ptw_req_dedup_queue: a cycle-by-cycle vector table for the main
// scenarios plus hand-written sequences for drop-count saturation and mid-run reset.
module tb_ptw_req_dedup_queue;

   localparam int ADDR_W = 27;

   logic              clock = 1'b0;
   logic              reset;
   logic              io_enq_ready;
   logic              io_enq_valid;
   logic              io_enq_bits_valid;
   logic [ADDR_W-1:0] io_enq_bits_bits_addr;
   logic              io_deq_ready;
   logic              io_deq_valid;
   logic [ADDR_W-1:0] io_deq_bits_addr;
   logic              io_resp_valid;
   logic              io_resp_err;
   logic [2:0]        io_count;
   logic [7:0]        io_drop_count;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clock = ~clock;

   ptw_req_dedup_queue #(.DEPTH(4), .ADDR_W(ADDR_W)) dut (
      .clock                 (clock),
      .reset                 (reset),
      .io_enq_ready          (io_enq_ready),
      .io_enq_valid          (io_enq_valid),
      .io_enq_bits_valid     (io_enq_bits_valid),
      .io_enq_bits_bits_addr (io_enq_bits_bits_addr),
      .io_deq_ready          (io_deq_ready),
      .io_deq_valid          (io_deq_valid),
      .io_deq_bits_addr      (io_deq_bits_addr),
      .io_resp_valid         (io_resp_valid),
      .io_resp_err           (io_resp_err),
      .io_count              (io_count),
      .io_drop_count         (io_drop_count)
   );

   // One row per cycle: inputs driven for this cycle, outputs expected before its edge.
   typedef struct packed {
      logic              ev;
      logic              bv;
      logic [ADDR_W-1:0] addr;
      logic              dr;
      logic              rv;
      logic              er;
      logic              dv;
      logic [ADDR_W-1:0] da;
      logic              re;
      logic [2:0]        cnt;
      logic [7:0]        dc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic ev, logic bv, logic [ADDR_W-1:0] addr, logic dr,
                               logic rv, logic er, logic dv, logic [ADDR_W-1:0] da,
                               logic re, logic [2:0] cnt, logic [7:0] dc);
      vec_t v;
      v.ev = ev; v.bv = bv; v.addr = addr; v.dr = dr; v.rv = rv;
      v.er = er; v.dv = dv; v.da = da; v.re = re; v.cnt = cnt; v.dc = dc;
      return v;
   endfunction

   task automatic chk(input string name, input int cyc, input logic [31:0] act,
                      input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic drive(input logic ev, input logic bv, input logic [ADDR_W-1:0] addr,
                        input logic dr, input logic rv);
      io_enq_valid          = ev;
      io_enq_bits_valid     = bv;
      io_enq_bits_bits_addr = addr;
      io_deq_ready          = dr;
      io_resp_valid         = rv;
   endtask

   task automatic chk_outs(input string tag, input int cyc, input logic er, input logic dv,
                           input logic [ADDR_W-1:0] da, input logic re,
                           input logic [2:0] cnt, input logic [7:0] dc);
      chk({tag, ".enq_ready"}, cyc, 32'(io_enq_ready), 32'(er));
      chk({tag, ".deq_valid"}, cyc, 32'(io_deq_valid), 32'(dv));
      if (dv) chk({tag, ".deq_addr"}, cyc, 32'(io_deq_bits_addr), 32'(da));
      chk({tag, ".resp_err"}, cyc, 32'(io_resp_err), 32'(re));
      chk({tag, ".count"}, cyc, 32'(io_count), 32'(cnt));
      chk({tag, ".drop_count"}, cyc, 32'(io_drop_count), 32'(dc));
   endtask

   initial begin
      // t1: single request round trip
      tbl.push_back(mk(1,1,27'h123, 1,0, 1,0,27'h0,  0,0,0));
      tbl.push_back(mk(0,0,27'h0,   1,0, 1,1,27'h123,0,1,0));
      tbl.push_back(mk(0,0,27'h0,   0,1, 1,0,27'h0,  0,1,0));
      tbl.push_back(mk(0,0,27'h0,   0,0, 1,0,27'h0,  0,0,0));
      // t2: duplicate of a pending address is dropped, order preserved
      tbl.push_back(mk(1,1,27'h10,  0,0, 1,0,27'h0,  0,0,0));
      tbl.push_back(mk(1,1,27'h20,  0,0, 1,1,27'h10, 0,1,0));
      tbl.push_back(mk(1,1,27'h10,  0,0, 1,1,27'h10, 0,2,0));
      tbl.push_back(mk(0,0,27'h0,   1,0, 1,1,27'h10, 0,2,1));
      tbl.push_back(mk(0,0,27'h0,   1,0, 1,1,27'h20, 0,2,1));
      tbl.push_back(mk(0,0,27'h0,   0,1, 1,0,27'h0,  0,2,1));
      tbl.push_back(mk(0,0,27'h0,   0,1, 1,0,27'h0,  0,1,1));
      tbl.push_back(mk(0,0,27'h0,   0,0, 1,0,27'h0,  0,0,1));
      // t3: fill to full, stalled enq, stray response
      tbl.push_back(mk(1,1,27'hA1,  0,0, 1,0,27'h0,  0,0,1));
      tbl.push_back(mk(1,1,27'hA2,  0,0, 1,1,27'hA1, 0,1,1));
      tbl.push_back(mk(1,1,27'hA3,  0,0, 1,1,27'hA1, 0,2,1));
      tbl.push_back(mk(1,1,27'hA4,  0,0, 1,1,27'hA1, 0,3,1));
      tbl.push_back(mk(1,1,27'hA5,  0,1, 0,1,27'hA1, 0,4,1));
      tbl.push_back(mk(0,0,27'h0,   0,0, 0,1,27'hA1, 1,4,1));
      tbl.push_back(mk(0,0,27'h0,   0,0, 0,1,27'hA1, 0,4,1));
      // drain
      tbl.push_back(mk(0,0,27'h0,   1,0, 0,1,27'hA1, 0,4,1));
      tbl.push_back(mk(0,0,27'h0,   1,1, 0,1,27'hA2, 0,4,1));
      tbl.push_back(mk(0,0,27'h0,   1,1, 1,1,27'hA3, 0,3,1));
      tbl.push_back(mk(0,0,27'h0,   1,1, 1,1,27'hA4, 0,2,1));
      tbl.push_back(mk(0,0,27'h0,   0,1, 1,0,27'h0,  0,1,1));
      tbl.push_back(mk(0,0,27'h0,   0,0, 1,0,27'h0,  0,0,1));
      // t4: duplicate of an entry retiring this same cycle is still dropped
      tbl.push_back(mk(1,1,27'h40,  0,0, 1,0,27'h0,  0,0,1));
      tbl.push_back(mk(0,0,27'h0,   1,0, 1,1,27'h40, 0,1,1));
      tbl.push_back(mk(1,1,27'h40,  0,1, 1,0,27'h0,  0,1,1));
      tbl.push_back(mk(1,1,27'h40,  0,0, 1,0,27'h0,  0,0,2));
      tbl.push_back(mk(0,0,27'h0,   0,0, 1,1,27'h40, 0,1,2));
      // t5: full with one in flight; enq+deq+resp together
      tbl.push_back(mk(0,0,27'h0,   1,0, 1,1,27'h40, 0,1,2));
      tbl.push_back(mk(1,1,27'hB1,  0,0, 1,0,27'h0,  0,1,2));
      tbl.push_back(mk(1,1,27'hB2,  0,0, 1,1,27'hB1, 0,2,2));
      tbl.push_back(mk(1,1,27'hB3,  0,0, 1,1,27'hB1, 0,3,2));
      tbl.push_back(mk(1,1,27'hC0,  1,1, 0,1,27'hB1, 0,4,2));
      tbl.push_back(mk(0,0,27'h0,   0,0, 1,1,27'hB2, 0,3,2));

      reset = 1'b1;
      drive(1, 1, 27'h55, 1, 1);
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk_outs("reset", -1, 1, 0, 27'h0, 0, 0, 0);
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         chk_outs("vec", i, tbl[i].er, tbl[i].dv, tbl[i].da, tbl[i].re, tbl[i].cnt, tbl[i].dc);
         $display("[TB] vec %0d enq=%0b/%0b addr=%0h deq_rdy=%0b resp=%0b -> cnt=%0d drops=%0d",
                  i, tbl[i].ev, tbl[i].bv, tbl[i].addr, tbl[i].dr, tbl[i].rv,
                  io_count, io_drop_count);
         drive(tbl[i].ev, tbl[i].bv, tbl[i].addr, tbl[i].dr, tbl[i].rv);
         @(negedge clock);
      end

      // t6: null requests (even with a matching address) saturate the drop counter
      for (int i = 0; i < 300; i++) begin
         if (i == 10) chk("null.drop_mid", i, 32'(io_drop_count), 32'd12);
         drive(1, 0, 27'hB2, 0, 0);
         @(negedge clock);
      end
      $display("[TB] 300 null requests -> cnt=%0d drops=%0d", io_count, io_drop_count);
      chk_outs("null", 300, 1, 1, 27'hB2, 0, 3, 8'd255);

      // Reset with 3 entries held; inputs active during reset must be ignored
      reset = 1'b1;
      drive(1, 1, 27'h77, 1, 1);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      drive(0, 0, 27'h0, 0, 0);
      $display("[TB] mid-run reset -> cnt=%0d deq_valid=%0b", io_count, io_deq_valid);
      chk_outs("rst2", 0, 1, 0, 27'h0, 0, 0, 0);

      // After reset nothing is in flight: a response is an error pulse
      drive(0, 0, 27'h0, 0, 1);
      @(negedge clock);
      drive(0, 0, 27'h0, 0, 0);
      $display("[TB] stray resp after reset -> resp_err=%0b", io_resp_err);
      chk_outs("stray", 1, 1, 0, 27'h0, 1, 0, 0);
      @(negedge clock);
      chk_outs("stray", 2, 1, 0, 27'h0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
